lsu_dm_ctrl: RTL and testbench

Load/store controller sitting between the EX/MEM pipeline stage and the byte-addressed data memory. It accepts one load or store request at a time over a valid/ready handshake. It generates the byte write enables, address and write data for the memory, captures read data, and returns sign- or zero-extended load results over a valid/ready response channel. It also range-checks addresses and rejects unsupported access sizes.

---
 rtl/lsu_pkg.sv | 43 ++++
 rtl/load_extend.sv | 33 +++
 rtl/lsu_dm_ctrl.sv | 168 ++++++++++++++++
 tb/tb_lsu_dm_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : lsu_pkg
// Purpose : Shared definitions for the load/store unit: RV32I load/store
//           funct3 encodings, byte-enable patterns and the controller's
//           state encoding.
// Ports   : none (package)
// Revision: 1.0  initial release
// ============================================================================
package lsu_pkg;

  // RV32I load/store size encodings
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Byte write-enable patterns for right-aligned store data
  localparam logic [3:0] BE_B = 4'b0001;
  localparam logic [3:0] BE_H = 4'b0011;
  localparam logic [3:0] BE_W = 4'b1111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } lsu_state_e;

  // Byte enables for a legal store size; 0 for anything else.
  function automatic logic [3:0] store_be(input logic [2:0] funct3);
    logic [3:0] be;
    case (funct3)
      F3_B:    be = BE_B;
      F3_H:    be = BE_H;
      F3_W:    be = BE_W;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage
`default_nettype wire

// File: rtl/load_extend.sv
`default_nettype none
// ============================================================================
// Module  : load_extend
// Purpose : Combinational load-result formatter. Takes the raw little-endian
//           word read at the access address and sign- or zero-extends the
//           low byte/half according to the RV32I load funct3.
// Ports   : funct3 [2:0]  load size/sign selector
//           raw    [31:0] raw memory data, byte 0 at bits [7:0]
//           result [31:0] extended load value
// Revision: 1.0  initial release
// ============================================================================
module load_extend
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] raw,
  output logic [31:0] result
);

  always_comb begin
    result = raw;
    case (funct3)
      F3_B:    result = {{24{raw[7]}}, raw[7:0]};
      F3_H:    result = {{16{raw[15]}}, raw[15:0]};
      F3_W:    result = raw;
      F3_BU:   result = {24'h000000, raw[7:0]};
      F3_HU:   result = {16'h0000, raw[15:0]};
      default: result = raw;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lsu_dm_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : lsu_dm_ctrl
// Purpose : Load/store controller between the EX/MEM stage and a
//           byte-addressed data memory. One request in flight; drives
//           registered memory controls for exactly one ACCESS cycle and
//           returns extended load data (or an error) on a response channel.
// Ports   : clk, rst_n                  clock, async active-low reset
//           req_valid/req_ready         request handshake (ready only in IDLE)
//           req_we, req_funct3          store flag and access size
//           req_addr, req_wdata         byte address, right-aligned store data
//           resp_valid/resp_ready       response handshake
//           resp_rdata, resp_err        extended load data, fault flag
//           dm_w_en, dm_address,        registered memory write enables,
//           dm_write_data               address and write data
//           dm_read_data                combinational memory read data
// Revision: 1.0  initial release
// ============================================================================
module lsu_dm_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_err,
  output logic [3:0]        dm_w_en,
  output logic [ADDR_W-1:0] dm_address,
  output logic [XLEN-1:0]   dm_write_data,
  input  logic [XLEN-1:0]   dm_read_data
);

  lsu_state_e        state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [3:0]        dm_w_en_q, dm_w_en_d;
  logic [ADDR_W-1:0] dm_address_q, dm_address_d;
  logic [XLEN-1:0]   dm_write_data_q, dm_write_data_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic [XLEN-1:0]   resp_rdata_q, resp_rdata_d;

  logic [XLEN-1:0]   load_ext;
  logic              addr_oob;
  logic              size_bad;
  logic              req_illegal;

  load_extend u_load_extend (
    .funct3 (funct3_q),
    .raw    (dm_read_data),
    .result (load_ext)
  );

  // Any address bit above the memory window is a fault; wrap within the
  // window (e.g. a word at the last byte) is allowed.
  assign addr_oob = |req_addr[XLEN-1:ADDR_W];

  always_comb begin
    size_bad = 1'b0;
    if (req_we) begin
      size_bad = (store_be(req_funct3) == 4'b0000);
    end else begin
      size_bad = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                 (req_funct3 == 3'b111);
    end
  end

  assign req_illegal = addr_oob || size_bad;

  // Qualified by rst_n so ready is low for the whole reset assertion.
  assign req_ready = (state_q == IDLE) && rst_n;

  always_comb begin
    state_d         = state_q;
    we_d            = we_q;
    funct3_d        = funct3_q;
    dm_w_en_d       = 4'b0000;
    dm_address_d    = dm_address_q;
    dm_write_data_d = dm_write_data_q;
    resp_valid_d    = resp_valid_q;
    resp_err_d      = resp_err_q;
    resp_rdata_d    = resp_rdata_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_illegal) begin
            // Fault: skip the memory entirely, respond next cycle.
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
            state_d      = RESP;
          end else begin
            we_d            = req_we;
            funct3_d        = req_funct3;
            dm_address_d    = req_addr[ADDR_W-1:0];
            dm_write_data_d = req_wdata;
            dm_w_en_d       = req_we ? store_be(req_funct3) : 4'b0000;
            state_d         = ACCESS;
          end
        end
      end

      ACCESS: begin
        // Store commits on this edge; load data is captured on it.
        resp_rdata_d = we_q ? '0 : load_ext;
        resp_valid_d = 1'b1;
        resp_err_d   = 1'b0;
        state_d      = RESP;
      end

      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          resp_err_d   = 1'b0;
          state_d      = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      we_q            <= 1'b0;
      funct3_q        <= 3'b000;
      dm_w_en_q       <= 4'b0000;
      dm_address_q    <= '0;
      dm_write_data_q <= '0;
      resp_valid_q    <= 1'b0;
      resp_err_q      <= 1'b0;
      resp_rdata_q    <= '0;
    end else begin
      state_q         <= state_d;
      we_q            <= we_d;
      funct3_q        <= funct3_d;
      dm_w_en_q       <= dm_w_en_d;
      dm_address_q    <= dm_address_d;
      dm_write_data_q <= dm_write_data_d;
      resp_valid_q    <= resp_valid_d;
      resp_err_q      <= resp_err_d;
      resp_rdata_q    <= resp_rdata_d;
    end
  end

  assign dm_w_en       = dm_w_en_q;
  assign dm_address    = dm_address_q;
  assign dm_write_data = dm_write_data_q;
  assign resp_valid    = resp_valid_q;
  assign resp_err      = resp_err_q;
  assign resp_rdata    = resp_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_dm_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_lsu_dm_ctrl
// Purpose : Self-checking bench for lsu_dm_ctrl with a byte-array data
//           memory model, a table of directed transactions and hand-written
//           sequences for back-pressure and mid-access reset.
// Revision: 1.0  initial release
// ============================================================================
module tb_lsu_dm_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [3:0]  dm_w_en;
  logic [15:0] dm_address;
  logic [31:0] dm_write_data;
  logic [31:0] dm_read_data;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lsu_dm_ctrl #(.ADDR_W(16), .XLEN(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_we        (req_we),
    .req_funct3    (req_funct3),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_rdata    (resp_rdata),
    .resp_err      (resp_err),
    .dm_w_en       (dm_w_en),
    .dm_address    (dm_address),
    .dm_write_data (dm_write_data),
    .dm_read_data  (dm_read_data)
  );

  // Byte-addressed memory, little-endian, addresses wrap at 64 KiB.
  logic [7:0] mem [0:65535];

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
  end

  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (dm_w_en[i]) mem[16'(dm_address + 16'(i))] <= dm_write_data[8*i +: 8];
    end
  end

  always_comb begin
    dm_read_data = {mem[16'(dm_address + 16'd3)], mem[16'(dm_address + 16'd2)],
                    mem[16'(dm_address + 16'd1)], mem[dm_address]};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One complete transaction starting at a negedge with the DUT in IDLE.
  // Returns response data/err, accept-to-resp_valid latency in cycles,
  // the number of cycles dm_w_en was nonzero and the last nonzero value.
  task automatic txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata, output logic [31:0] rd, output logic err,
                     output int lat, output int wcyc, output logic [3:0] wseen);
    rd = 32'h0; err = 1'b0; lat = 0; wcyc = 0; wseen = 4'b0000;
    req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      lat++;
      if (dm_w_en != 4'b0000) begin wcyc++; wseen = dm_w_en; end
      if (resp_valid) break;
    end
    if (resp_valid) begin
      rd = resp_rdata; err = resp_err;
      resp_ready = 1'b1;
      @(posedge clk);
      #1 resp_ready = 1'b0;
      @(negedge clk);
    end else begin
      lat = 99;
    end
  endtask

  typedef struct {
    string       name;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
    logic [3:0]  exp_wen;
  } vec_t;

  vec_t vecs[$];

  logic [31:0] rd;
  logic        err;
  int          lat, wcyc;
  logic [3:0]  wseen;
  logic [31:0] held;

  initial begin
    //              name          we   f3      addr          wdata         exp_rd        err lat wen
    vecs.push_back('{"sw_100",    1'b1, 3'b010, 32'h0000_0100, 32'hDEADBEEF, 32'h00000000, 1'b0, 2, 4'b1111});
    vecs.push_back('{"lw_100",    1'b0, 3'b010, 32'h0000_0100, 32'h0,        32'hDEADBEEF, 1'b0, 2, 4'b0000});
    vecs.push_back('{"sb_200",    1'b1, 3'b000, 32'h0000_0200, 32'h12345680, 32'h00000000, 1'b0, 2, 4'b0001});
    vecs.push_back('{"lb_200",    1'b0, 3'b000, 32'h0000_0200, 32'h0,        32'hFFFFFF80, 1'b0, 2, 4'b0000});
    vecs.push_back('{"lbu_200",   1'b0, 3'b100, 32'h0000_0200, 32'h0,        32'h00000080, 1'b0, 2, 4'b0000});
    vecs.push_back('{"lw_200",    1'b0, 3'b010, 32'h0000_0200, 32'h0,        32'h00000080, 1'b0, 2, 4'b0000});
    vecs.push_back('{"sh_ffff",   1'b1, 3'b001, 32'h0000_FFFF, 32'h0000A5C3, 32'h00000000, 1'b0, 2, 4'b0011});
    vecs.push_back('{"lhu_ffff",  1'b0, 3'b101, 32'h0000_FFFF, 32'h0,        32'h0000A5C3, 1'b0, 2, 4'b0000});
    vecs.push_back('{"lh_ffff",   1'b0, 3'b001, 32'h0000_FFFF, 32'h0,        32'hFFFFA5C3, 1'b0, 2, 4'b0000});
    vecs.push_back('{"lw_oob",    1'b0, 3'b010, 32'h0001_0000, 32'h0,        32'h00000000, 1'b1, 1, 4'b0000});
    vecs.push_back('{"sb_f3_011", 1'b1, 3'b011, 32'h0000_0100, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1, 4'b0000});
    vecs.push_back('{"sw_f3_100", 1'b1, 3'b100, 32'h0000_0100, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1, 4'b0000});
    vecs.push_back('{"ld_f3_011", 1'b0, 3'b011, 32'h0000_0100, 32'h0,        32'h00000000, 1'b1, 1, 4'b0000});
    vecs.push_back('{"sw_oob",    1'b1, 3'b010, 32'h8000_0100, 32'h55555555, 32'h00000000, 1'b1, 1, 4'b0000});
    vecs.push_back('{"lw_100_unc",1'b0, 3'b010, 32'h0000_0100, 32'h0,        32'hDEADBEEF, 1'b0, 2, 4'b0000});
    vecs.push_back('{"lh_100",    1'b0, 3'b001, 32'h0000_0100, 32'h0,        32'hFFFFBEEF, 1'b0, 2, 4'b0000});
    vecs.push_back('{"lhu_102",   1'b0, 3'b101, 32'h0000_0102, 32'h0,        32'h0000DEAD, 1'b0, 2, 4'b0000});
    vecs.push_back('{"lb_103",    1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'hFFFFFFDE, 1'b0, 2, 4'b0000});
    vecs.push_back('{"lw_101_mis",1'b0, 3'b010, 32'h0000_0101, 32'h0,        32'h00DEADBE, 1'b0, 2, 4'b0000});
    vecs.push_back('{"sw_fffe",   1'b1, 3'b010, 32'h0000_FFFE, 32'h11223344, 32'h00000000, 1'b0, 2, 4'b1111});
    vecs.push_back('{"lw_fffe",   1'b0, 3'b010, 32'h0000_FFFE, 32'h0,        32'h11223344, 1'b0, 2, 4'b0000});
    vecs.push_back('{"lbu_0000",  1'b0, 3'b100, 32'h0000_0000, 32'h0,        32'h00000022, 1'b0, 2, 4'b0000});

    // ---- reset state ----
    #2;
    chk("rst_req_ready_low", {31'b0, req_ready}, 32'h0);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
    chk("rst_dm_w_en", {28'b0, dm_w_en}, 32'h0);
    chk("rst_dm_address", {16'b0, dm_address}, 32'h0);
    chk("rst_dm_wdata", dm_write_data, 32'h0);
    chk("rst_resp_rdata", resp_rdata, 32'h0);
    chk("rst_resp_err", {31'b0, resp_err}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_req_ready", {31'b0, req_ready}, 32'h1);

    // ---- table of transactions ----
    foreach (vecs[i]) begin
      chk({vecs[i].name, "_req_ready"}, {31'b0, req_ready}, 32'h1);
      txn(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, err, lat, wcyc, wseen);
      chk({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rd);
      chk({vecs[i].name, "_err"}, {31'b0, err}, {31'b0, vecs[i].exp_err});
      chk({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].exp_lat));
      chk({vecs[i].name, "_wen"}, {28'b0, wseen}, {28'b0, vecs[i].exp_wen});
      chk({vecs[i].name, "_wen_cycles"}, 32'(wcyc), (vecs[i].exp_wen != 4'b0000) ? 32'd1 : 32'd0);
      if (vecs[i].name == "sh_ffff") begin
        chk("sh_ffff_mem_ffff", {24'b0, mem[16'hFFFF]}, 32'h000000C3);
        chk("sh_ffff_mem_0000", {24'b0, mem[16'h0000]}, 32'h000000A5);
      end
      if (vecs[i].name == "sw_oob") begin
        chk("sw_oob_mem_unchanged", {mem[16'h0103], mem[16'h0102], mem[16'h0101], mem[16'h0100]}, 32'hDEADBEEF);
      end
    end

    // ---- back-pressure: LW 0x100 held for 5 cycles, pending LW 0x200 ----
    req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h0000_0100; req_valid = 1'b1;
    @(posedge clk);
    #1 req_addr = 32'h0000_0200;  // next request stays presented
    lat = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      lat++;
      if (resp_valid) break;
    end
    chk("bp_lat", 32'(lat), 32'd2);
    held = resp_rdata;
    chk("bp_rdata", held, 32'hDEADBEEF);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_valid_held", {31'b0, resp_valid}, 32'h1);
      chk("bp_rdata_stable", resp_rdata, 32'hDEADBEEF);
      chk("bp_req_ready_low", {31'b0, req_ready}, 32'h0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);
    // Pending request must not have been taken on the handshake edge.
    chk("bp_idle_after_hs", {31'b0, req_ready}, 32'h1);
    chk("bp_valid_dropped", {31'b0, resp_valid}, 32'h0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      lat++;
      if (resp_valid) break;
    end
    chk("pend_lat", 32'(lat), 32'd2);
    chk("pend_rdata", resp_rdata, 32'h00000080);
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    @(negedge clk);

    // ---- reset during ACCESS of SW 0x300 ----
    req_we = 1'b1; req_funct3 = 3'b010; req_addr = 32'h0000_0300;
    req_wdata = 32'h11111111; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    chk("rstacc_wen_before", {28'b0, dm_w_en}, 32'h0000000F);
    rst_n = 1'b0;
    #1;
    chk("rstacc_wen_dropped", {28'b0, dm_w_en}, 32'h0);
    chk("rstacc_resp_valid", {31'b0, resp_valid}, 32'h0);
    chk("rstacc_req_ready_low", {31'b0, req_ready}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstacc_req_ready", {31'b0, req_ready}, 32'h1);
    txn(1'b0, 3'b010, 32'h0000_0300, 32'h0, rd, err, lat, wcyc, wseen);
    chk("rstacc_lw_old", rd, 32'h00000000);
    chk("rstacc_lw_lat", 32'(lat), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
